// File: rtl/switch_debouncer.sv
// Per-channel switch conditioner: two-flop synchroniser, tick-based stability
// qualification, clean level output plus a one-clk change pulse.
module switch_debouncer #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned STABLE_TICKS = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_debounced,
    output logic [WIDTH-1:0] sw_changed,
    output logic             sample_tick
);

    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CNT_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    logic [WIDTH-1:0] deb_next;
    logic [WIDTH-1:0] chg_next;

    // Metastability guard for the asynchronous pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    // Free-running prescaler; the tick is registered off the terminal count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt     <= '0;
            sample_tick <= 1'b0;
        end else if (div_cnt == DIV_MAX) begin
            div_cnt     <= '0;
            sample_tick <= 1'b1;
        end else begin
            div_cnt     <= div_cnt + DIV_W'(1);
            sample_tick <= 1'b0;
        end
    end

    // A return to the accepted level restarts qualification on any clk.
    always_comb begin
        deb_next = sw_debounced;
        chg_next = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_next[i] = cnt[i];
            if (sync2[i] == sw_debounced[i]) begin
                cnt_next[i] = '0;
            end else if (sample_tick) begin
                if (cnt[i] == CNT_MAX) begin
                    deb_next[i] = sync2[i];
                    cnt_next[i] = '0;
                    chg_next[i] = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_debounced <= '0;
            sw_changed   <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sw_debounced <= deb_next;
            sw_changed   <= chg_next;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
Conditions raw board slide-switch/push-button inputs before they reach the 8-bit switches PIO `in_port`. Per channel:
- synchronises the input to clk;
- removes contact bounce with a tick-based stability counter;
- presents a clean level plus a one-cycle change pulse.

Because the PIO's own edge detector runs on this output, each physical toggle produces exactly one captured edge.

Parameters:
WIDTH, 8, number of independent switch channels.
TICK_DIV, 50000, clk cycles per sample tick (1 ms at 50 MHz); legal range >= 1.
STABLE_TICKS, 10, consecutive ticks a new level must persist before it is accepted; legal range >= 1.

Ports:
clk  in  1  system clock.
reset_n  in  1  reset, asynchronous, active-low.
sw_raw  in  WIDTH  asynchronous raw switch pins.
sw_debounced  out  WIDTH  debounced level; connects to the PIO `in_port`.
sw_changed  out  WIDTH  one-clk pulse per channel when `sw_debounced[i]` updates.
sample_tick  out  1  prescaler tick, one clk wide; for debug/visibility.

Behaviour:
- Reset (async, reset_n=0): all state clears immediately.
  - Cleared: sync stages, prescaler, channel counters, sw_debounced=0, sw_changed=0, sample_tick=0.
  - Reset mid-count discards partial counts; counting restarts from 0 after release.
- Synchroniser: two-flop chain `sync1 <= sw_raw`, `sync2 <= sync1`, reset 0. All channel logic uses `sync2` only.
- Prescaler: counter 0..TICK_DIV-1, free-running.
  - sample_tick=1 (registered) in the cycle after the counter reaches TICK_DIV-1; the counter then wraps to 0.
  - First tick occurs TICK_DIV clks after reset release. TICK_DIV=1 gives a tick every clk.
  - Counter width is `clog2(TICK_DIV)`, minimum 1.
- Per-channel counter `cnt[i]`, width `clog2(STABLE_TICKS)`, minimum 1. Priority, evaluated every clk:
  1. `sync2[i] == sw_debounced[i]`: `cnt[i] <= 0`. Applies on any clk, tick or not, so any glitch back to the accepted level restarts qualification.
  2. Mismatch and tick and `cnt[i] == STABLE_TICKS-1`:
     - `sw_debounced[i] <= sync2[i]`
     - `cnt[i] <= 0`
     - `sw_changed[i] <= 1`
  3. Mismatch and tick otherwise: `cnt[i] <= cnt[i] + 1`.
  4. Else: hold.
- sw_changed: registered; defaults to 0 each clk, so pulses are exactly one clk wide. It is asserted in the same cycle `sw_debounced` takes its new value.
- Latency from a clean, held `sw_raw` step to `sw_debounced` update:
  - 2 sync clks, plus
  - between (STABLE_TICKS-1)*TICK_DIV+1 and STABLE_TICKS*TICK_DIV clks, depending on tick phase.
- Rising and falling transitions are symmetric.
- Channels are fully independent. Simultaneous qualifications update in the same clk, with multiple `sw_changed` bits set.
- At most one `sw_debounced` transition per channel per STABLE_TICKS ticks.
- No counter saturation issue: `cnt` never exceeds STABLE_TICKS-1.
- Pulses on sw_raw shorter than 2 clks may be missed by the synchroniser; this is acceptable.

Test Plan (bench parameters TICK_DIV=4, STABLE_TICKS=3, WIDTH=8):
1. Reset/prescaler: hold reset_n=0 with sw_raw=0xFF.
   -> sw_debounced=0x00, sw_changed=0x00.
   -> After release, sample_tick pulses first at clk 4, then every 4 clks, each pulse 1 clk wide.
2. Clean step: sw_raw[0] 0->1 and held.
   -> sw_debounced[0] rises within 2+9..2+12 clks (tick-phase dependent) of the change.
   -> sw_changed=0x01 for exactly 1 clk, coincident with the rise.
   -> Then sw_debounced=0x01 and sw_changed=0x00.
3. Bounce rejection: sw_raw[3] high for 6 clks, low 1 clk, repeated for 40 clks, then held low.
   -> sw_debounced[3] stays 0 and sw_changed[3] never asserts.
4. Bounce then settle: sw_raw[3] toggles every 3 clks for 20 clks, then held 1.
   -> Exactly one sw_changed[3] pulse.
   -> sw_debounced[3]=1 no earlier than 9 clks after the final toggle.
5. Simultaneous channels: sw_raw 0x00->0x81 in one clk.
   -> sw_debounced 0x00->0x81 in a single clk, with sw_changed=0x81 for 1 clk.
   -> Then sw_raw 0x81->0x00 gives the symmetric falling response, sw_changed=0x81.
6. Reset mid-operation: sw_raw[5]=1 held for 2 ticks, then reset_n=0 for 3 clks, then released with sw_raw[5] still 1.
   -> Outputs are 0 immediately on reset assertion.
   -> sw_debounced[5] rises only after a full fresh 3-tick qualification, with no pulse carried over from before reset.
